// File: rtl/cv32e40x_clmul_unit_if.sv
// Request/response bundle for the carry-less multiply unit.
// The unit side is the slave; the issuing pipeline side is the master.
interface cv32e40x_clmul_unit_if;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    modport master (
        output valid_i, op_i, op_a_i, op_b_i, kill_i, ready_i,
        input  ready_o, valid_o, result_o
    );

    modport slave (
        input  valid_i, op_i, op_a_i, op_b_i, kill_i, ready_i,
        output ready_o, valid_o, result_o
    );
endinterface

// File: rtl/cv32e40x_clmul_unit.sv
// Iterative carry-less multiplier (CLMUL/CLMULH/CLMULR), BITS_PER_CYCLE bits of rs2 per cycle.
// state | meaning: IDLE accept request | BUSY accumulate partial products | DONE hold result until taken
module cv32e40x_clmul_unit #(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cv32e40x_clmul_unit_if.slave     bus
);

    localparam int unsigned N_ITER = 32 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       acc_q, acc_d;
    logic [63:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       partial;
    logic [31:0]       sel_word;

    // a_q is pre-shifted by the slice position, so each cycle only needs shifts 0..BITS_PER_CYCLE-1
    always_comb begin
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (b_q[j]) begin
                partial = partial ^ (a_q << j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        if (bus.kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i && bus.ready_o) begin
                        a_d     = {32'b0, bus.op_a_i};
                        b_d     = bus.op_b_i;
                        op_d    = bus.op_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    acc_d = acc_q ^ partial;
                    a_d   = a_q << BITS_PER_CYCLE;
                    b_d   = b_q >> BITS_PER_CYCLE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reserved op 11 falls through to the CLMUL word
    always_comb begin
        case (op_q)
            2'b01:   sel_word = acc_q[63:32];
            2'b10:   sel_word = acc_q[62:31];
            default: sel_word = acc_q[31:0];
        endcase
    end

    assign bus.ready_o  = (state_q == IDLE) && !bus.kill_i && !rst;
    assign bus.valid_o  = (state_q == DONE) && !bus.kill_i;
    assign bus.result_o = bus.valid_o ? sel_word : 32'b0;

endmodule

// File: doc/cv32e40x_clmul_unit.md
CV32E40X_CLMUL_UNIT -- requirements
Module: cv32e40x_clmul_unit

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 4: op_b bits consumed per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter N_ITER = 32/BITS_PER_CYCLE, derived and not overridable.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port valid_i, input, 1: request valid.
REQ-006 SHALL have port ready_o, output, 1: unit can accept a request.
REQ-007 SHALL have port op_i, input, 2: 00 = CLMUL, 01 = CLMULH, 10 = CLMULR, 11 = reserved.
REQ-008 SHALL have port op_a_i, input, 32: rs1 operand.
REQ-009 SHALL have port op_b_i, input, 32: rs2 operand.
REQ-010 SHALL have port kill_i, input, 1: pipeline flush.
REQ-011 SHALL have port valid_o, output, 1: result valid.
REQ-012 SHALL have port ready_i, input, 1: consumer accepts the result.
REQ-013 SHALL have port result_o, output, 32: selected product word.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, BUSY, DONE.
REQ-015 SHALL drive ready_o = 1 only in IDLE, and only while kill_i = 0.
REQ-016 SHALL take the handshake in IDLE when valid_i & ready_o: latch op_a_i, op_b_i and op_i; clear the 64-bit accumulator and the iteration counter; go to BUSY.
REQ-017 SHALL, in each BUSY cycle, XOR into the accumulator (op_a << j) for every set bit j of the current BITS_PER_CYCLE-wide op_b slice, processed LSB slice first, then increment the counter.
REQ-018 SHALL go BUSY -> DONE on the cycle the counter reaches N_ITER-1, so valid_o first rises N_ITER clock edges after the accepting edge (8 with the default).
REQ-019 SHALL select result_o by the latched op: CLMUL = prod[31:0]; CLMULH = prod[63:32]; CLMULR = prod[62:31]. prod[63] is always 0.
REQ-020 SHALL treat op 11 as CLMUL.
REQ-021 SHALL drive valid_o = 1 only in DONE; result_o and valid_o hold stable until ready_i = 1.
REQ-022 SHALL go DONE -> IDLE when valid_o & ready_i; a new request is not accepted in that same cycle (no overlap).
REQ-023 SHALL return to IDLE from any state on the next edge when kill_i = 1, discarding the operation; valid_o is 0 during that cycle.
REQ-024 SHALL let kill_i dominate valid_i in the same cycle: no request is accepted.
REQ-025 SHALL drive result_o = 0 whenever valid_o = 0.
REQ-026 SHALL behave identically for any op_a or op_b value, including 0; there is no early termination.
REQ-027 SHALL keep the counter width at clog2(N_ITER), minimum 1 bit; the counter never wraps within an operation.

Reset
REQ-028 SHALL, on rst = 1, asynchronously force: state IDLE, accumulator 0, counter 0, latched operands 0, latched op 00.
REQ-029 SHALL, during reset, drive outputs ready_o = 0, valid_o = 0, result_o = 0.
REQ-030 SHALL, with rst asserted mid-BUSY or mid-DONE, abort the operation; after deassertion the unit is in IDLE with ready_o = 1 and produces no stale result.

Verification
REQ-031 SHALL cover: CLMUL, a = 0x00000003, b = 0x00000003 -> result 0x00000005; valid_o high exactly 8 edges after the handshake (default parameter).
REQ-032 SHALL cover: a = b = 0x80000000 -> CLMUL 0x00000000, CLMULH 0x40000000, CLMULR 0x80000000.
REQ-033 SHALL cover: a = b = 0xFFFFFFFF -> CLMUL 0x55555555, CLMULH 0x55555555, CLMULR 0xAAAAAAAA.
REQ-034 SHALL cover: ready_i held 0 for 5 cycles in DONE -> valid_o and result_o stable throughout; ready_o = 0; a new valid_i is not accepted.
REQ-035 SHALL cover: kill_i pulsed in BUSY cycle 3 together with valid_i -> IDLE next edge; no valid_o; the following request produces a correct result.
REQ-036 SHALL cover: rst asserted in DONE -> all outputs 0 immediately; after release ready_o = 1; the result matches a golden model for 10k random operands across all BITS_PER_CYCLE values.
